// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester/CDB bundle between writeback units and the arbiter
// Ports (bundle signals):
//   req_valid[NREQ]            requester i presents a result
//   req_robid[NREQ*ROB_BITS]   RoB id, slice i at [i*ROB_BITS +: ROB_BITS]
//   req_value[NREQ*32]         result value, slice i at [i*32 +: 32]
//   req_ready[NREQ]            slot i accepts this cycle
//   cdb_valid/robid/value/src  registered broadcast
// master: requester side, slave: arbiter side.
interface cdb_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int ROB_BITS = 4
) ();
  localparam int SRC_BITS = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*ROB_BITS-1:0] req_robid;
  logic [NREQ*32-1:0]       req_value;
  logic [NREQ-1:0]          req_ready;
  logic                     cdb_valid;
  logic [ROB_BITS-1:0]      cdb_robid;
  logic [31:0]              cdb_value;
  logic [SRC_BITS-1:0]      cdb_src;

  modport master (
    output req_valid, req_robid, req_value,
    input  req_ready, cdb_valid, cdb_robid, cdb_value, cdb_src
  );

  modport slave (
    input  req_valid, req_robid, req_value,
    output req_ready, cdb_valid, cdb_robid, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter for the reorder-buffer CDB write port
// Ports:
//   clk_in    system clock
//   rst_in    asynchronous active-low reset
//   rdy_in    pause when low; all state holds
//   flush_in  discard all pending and in-flight results
//   bus       cdb_arbiter_if.slave (requests in, registered CDB broadcast out)
// Optional feature macro: CDB_BYPASS_EN (a request into an empty slot may win
// arbitration in the same cycle and be broadcast without occupying the slot).
module cdb_arbiter #(
  parameter int NREQ     = 4,
  parameter int ROB_BITS = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_BITS = $clog2(NREQ);

  logic [NREQ-1:0]     slot_full_q, slot_full_d;
  logic [ROB_BITS-1:0] slot_robid_q [NREQ];
  logic [ROB_BITS-1:0] slot_robid_d [NREQ];
  logic [31:0]         slot_value_q [NREQ];
  logic [31:0]         slot_value_d [NREQ];
  logic [SRC_BITS-1:0] ptr_q, ptr_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [ROB_BITS-1:0] cdb_robid_q, cdb_robid_d;
  logic [31:0]         cdb_value_q, cdb_value_d;
  logic [SRC_BITS-1:0] cdb_src_q, cdb_src_d;

  logic                active;
  logic [NREQ-1:0]     cand;
  logic [NREQ-1:0]     grant_vec;
  logic                grant_any;
  logic [SRC_BITS-1:0] grant_idx;
  logic [SRC_BITS:0]   scan_wide;
  logic [SRC_BITS-1:0] scan_idx;
  logic [NREQ-1:0]     ready_vec;
  logic [NREQ-1:0]     capture;
  logic [ROB_BITS-1:0] g_robid;
  logic [31:0]         g_value;

  // rst_in gates acceptance so req_ready is low for the whole reset window.
  assign active    = rst_in && rdy_in && !flush_in;
  assign ready_vec = {NREQ{active}} & (~slot_full_q | grant_vec);

  // Scan from ptr upward, wrapping modulo NREQ; first candidate wins.
  always_comb begin
    cand = slot_full_q;
`ifdef CDB_BYPASS_EN
    cand = slot_full_q | bus.req_valid;
`endif
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_wide = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_wide = {1'b0, ptr_q} + (SRC_BITS + 1)'(k);
      if (scan_wide >= (SRC_BITS + 1)'(NREQ)) begin
        scan_idx = SRC_BITS'(scan_wide - (SRC_BITS + 1)'(NREQ));
      end else begin
        scan_idx = SRC_BITS'(scan_wide);
      end
      if (!grant_any && active && cand[scan_idx]) begin
        grant_any           = 1'b1;
        grant_vec[scan_idx] = 1'b1;
        grant_idx           = scan_idx;
      end
    end
  end

  // Winner payload: slot contents, or the live request when bypassing an empty slot.
  always_comb begin
    g_robid = slot_robid_q[grant_idx];
    g_value = slot_value_q[grant_idx];
`ifdef CDB_BYPASS_EN
    if (!slot_full_q[grant_idx]) begin
      g_robid = bus.req_robid[grant_idx*ROB_BITS +: ROB_BITS];
      g_value = bus.req_value[grant_idx*32 +: 32];
    end
`endif
  end

  // A bypassed winner is broadcast directly and never lands in its slot.
  always_comb begin
    capture = bus.req_valid & ready_vec;
`ifdef CDB_BYPASS_EN
    capture = capture & ~(grant_vec & ~slot_full_q);
`endif
  end

  always_comb begin
    slot_full_d  = slot_full_q;
    slot_robid_d = slot_robid_q;
    slot_value_d = slot_value_q;
    ptr_d        = ptr_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_robid_d  = cdb_robid_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    if (rdy_in) begin
      if (flush_in) begin
        slot_full_d = '0;
        cdb_valid_d = 1'b0;
        ptr_d       = '0;
      end else begin
        cdb_valid_d = grant_any;
        if (grant_any) begin
          cdb_robid_d = g_robid;
          cdb_value_d = g_value;
          cdb_src_d   = grant_idx;
          ptr_d       = (grant_idx == SRC_BITS'(NREQ - 1)) ? '0 : grant_idx + SRC_BITS'(1);
        end
        // Clear the granted slot first so a same-cycle refill lands on top.
        slot_full_d = slot_full_q & ~grant_vec;
        for (int i = 0; i < NREQ; i++) begin
          if (capture[i]) begin
            slot_full_d[i]  = 1'b1;
            slot_robid_d[i] = bus.req_robid[i*ROB_BITS +: ROB_BITS];
            slot_value_d[i] = bus.req_value[i*32 +: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_full_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_robid_q[i] <= '0;
        slot_value_q[i] <= '0;
      end
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_robid_q <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      slot_full_q  <= slot_full_d;
      slot_robid_q <= slot_robid_d;
      slot_value_q <= slot_value_d;
      ptr_q        <= ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_robid_q  <= cdb_robid_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_robid = cdb_robid_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule
